// File: rtl/bus_to_bb_addr_bridge.sv
// Inbound bus-to-bridge request converter: window check, address
// un-mapping, error capture and a 2-entry FIFO to the bridge side.
module bus_to_bb_addr_bridge #(
  parameter int BB_ADDR_WIDTH      = 12,
  parameter int BUS_ADDR_WIDTH     = 16,
  parameter int BUS_MEM_ADDR_WIDTH = 12,
  parameter int DATA_WIDTH         = 8
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      bus_req_valid,
  output logic                      bus_req_ready,
  input  logic [BUS_ADDR_WIDTH-1:0] bus_req_addr,
  input  logic                      bus_req_we,
  input  logic [DATA_WIDTH-1:0]     bus_req_wdata,
  output logic                      bb_req_valid,
  input  logic                      bb_req_ready,
  output logic [BB_ADDR_WIDTH-1:0]  bb_addr,
  output logic                      bb_we,
  output logic [DATA_WIDTH-1:0]     bb_wdata,
  output logic                      addr_err,
  output logic [BUS_ADDR_WIDTH-1:0] err_addr,
  output logic [7:0]                err_count,
  input  logic                      err_clr
);

  typedef struct packed {
    logic [BB_ADDR_WIDTH-1:0] addr;
    logic                     we;
    logic [DATA_WIDTH-1:0]    wdata;
  } entry_t;

  // Bits that must be clear for an address to fall inside the window.
  function automatic logic [BUS_ADDR_WIDTH-1:0] bad_mask();
    logic [BUS_ADDR_WIDTH-1:0] m;
    m = '0;
    for (int i = 0; i < BUS_ADDR_WIDTH; i++) begin
      if (i > BUS_MEM_ADDR_WIDTH ||
          (i >= BB_ADDR_WIDTH - 1 && i < BUS_MEM_ADDR_WIDTH))
        m[i] = 1'b1;
    end
    return m;
  endfunction

  localparam logic [BUS_ADDR_WIDTH-1:0] BAD_MASK = bad_mask();

  entry_t     mem [2];
  entry_t     new_entry;
  entry_t     head;
  logic       rd_ptr;
  logic       wr_ptr;
  logic [1:0] count;
  logic       accept;
  logic       in_win;
  logic       push;
  logic       drop;
  logic       pop;

  assign bus_req_ready = (count < 2'd2);
  assign bb_req_valid  = (count != 2'd0);

  assign accept = bus_req_valid & bus_req_ready;
  assign in_win = ((bus_req_addr & BAD_MASK) == '0);
  assign push   = accept & in_win;
  assign drop   = accept & ~in_win;
  assign pop    = bb_req_valid & bb_req_ready;

  always_comb begin
    new_entry       = '0;
    new_entry.addr  = {bus_req_addr[BUS_MEM_ADDR_WIDTH],
                       bus_req_addr[BB_ADDR_WIDTH-2:0]};
    new_entry.we    = bus_req_we;
    new_entry.wdata = bus_req_wdata;
  end

  always_comb begin
    head = '0;
    if (bb_req_valid)
      head = mem[rd_ptr];
  end

  assign bb_addr  = head.addr;
  assign bb_we    = head.we;
  assign bb_wdata = head.wdata;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mem[0] <= '0;
      mem[1] <= '0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= new_entry;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop)
        rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      addr_err  <= 1'b0;
      err_addr  <= '0;
      err_count <= 8'd0;
    end else begin
      addr_err <= drop;
      if (drop)
        err_addr <= bus_req_addr;
      if (err_clr)
        err_count <= drop ? 8'd1 : 8'd0;
      else if (drop && err_count != 8'hFF)
        err_count <= err_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_bus_to_bb_addr_bridge.sv
// Self-checking bench for bus_to_bb_addr_bridge: scoreboard on the
// bridge side plus directed checks of window errors and reset.
module tb_bus_to_bb_addr_bridge;

  logic        clk;
  logic        rstn;
  logic        bus_req_valid;
  logic        bus_req_ready;
  logic [15:0] bus_req_addr;
  logic        bus_req_we;
  logic [7:0]  bus_req_wdata;
  logic        bb_req_valid;
  logic        bb_req_ready;
  logic [11:0] bb_addr;
  logic        bb_we;
  logic [7:0]  bb_wdata;
  logic        addr_err;
  logic [15:0] err_addr;
  logic [7:0]  err_count;
  logic        err_clr;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [11:0] addr;
    logic        we;
    logic [7:0]  wd;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;

  bus_to_bb_addr_bridge dut (
    .clk           (clk),
    .rstn          (rstn),
    .bus_req_valid (bus_req_valid),
    .bus_req_ready (bus_req_ready),
    .bus_req_addr  (bus_req_addr),
    .bus_req_we    (bus_req_we),
    .bus_req_wdata (bus_req_wdata),
    .bb_req_valid  (bb_req_valid),
    .bb_req_ready  (bb_req_ready),
    .bb_addr       (bb_addr),
    .bb_we         (bb_we),
    .bb_wdata      (bb_wdata),
    .addr_err      (addr_err),
    .err_addr      (err_addr),
    .err_count     (err_count),
    .err_clr       (err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit is_bad(input logic [15:0] a);
    return (a[15:13] != 3'b000) || a[11];
  endfunction

  function automatic logic [11:0] conv(input logic [15:0] a);
    return {a[12], a[10:0]};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Pops happen on the next rising edge; inputs only change just after one.
  always @(negedge clk) begin
    if (rstn && bb_req_valid && bb_req_ready) begin
      total++;
      if (sbq.size() == 0) begin
        bad++;
        $display("FAIL sb_unexpected: got addr=%h we=%b wd=%h, want none",
                 bb_addr, bb_we, bb_wdata);
      end else begin
        mon_e = sbq.pop_front();
        if ({bb_addr, bb_we, bb_wdata} !==
            {mon_e.addr, mon_e.we, mon_e.wd}) begin
          bad++;
          $display("FAIL sb_entry: got %h/%b/%h, want %h/%b/%h",
                   bb_addr, bb_we, bb_wdata,
                   mon_e.addr, mon_e.we, mon_e.wd);
        end
      end
    end
  end

  task automatic send(input logic [15:0] a, input logic we,
                      input logic [7:0] wd);
    bit ok;
    ok = 0;
    bus_req_valid = 1'b1;
    bus_req_addr  = a;
    bus_req_we    = we;
    bus_req_wdata = wd;
    for (int k = 0; k < 50 && !ok; k++) begin
      if (bus_req_ready) begin
        if (!is_bad(a))
          sbq.push_back('{conv(a), we, wd});
        ok = 1;
      end
      step();
    end
    bus_req_valid = 1'b0;
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL send_timeout: addr=%h ready=%b, want ready=1",
               a, bus_req_ready);
    end
  endtask

  task automatic drain();
    for (int k = 0; k < 20 && sbq.size() != 0; k++)
      step();
    total++;
    if (sbq.size() != 0) begin
      bad++;
      $display("FAIL drain_timeout: pending=%0d, want 0", sbq.size());
    end
  endtask

  task automatic test_reset();
    total++;
    if ({bb_req_valid, bus_req_ready, addr_err, err_addr, err_count,
         bb_addr, bb_we, bb_wdata} !== {1'b0, 1'b1, 1'b0, 16'h0, 8'h0,
         12'h0, 1'b0, 8'h0}) begin
      bad++;
      $display("FAIL reset_state: v=%b rdy=%b err=%b ea=%h ec=%0d a=%h",
               bb_req_valid, bus_req_ready, addr_err, err_addr,
               err_count, bb_addr);
    end
  endtask

  task automatic test_single();
    bb_req_ready = 1'b1;
    send(16'h12BC, 1'b1, 8'h5A);
    total++;
    if ({bb_req_valid, bb_addr, bb_we, bb_wdata} !==
        {1'b1, 12'hABC, 1'b1, 8'h5A}) begin
      bad++;
      $display("FAIL single_latency: v=%b a=%h we=%b wd=%h, want 1/abc/1/5a",
               bb_req_valid, bb_addr, bb_we, bb_wdata);
    end
    step();
    total++;
    if (bb_req_valid !== 1'b0) begin
      bad++;
      $display("FAIL single_pop: valid=%b, want 0", bb_req_valid);
    end
  endtask

  task automatic test_window_err();
    bb_req_ready  = 1'b1;
    bus_req_valid = 1'b1;
    bus_req_addr  = 16'h0800;
    bus_req_we    = 1'b0;
    step();
    total++;
    if ({addr_err, err_addr, err_count, bb_req_valid} !==
        {1'b1, 16'h0800, 8'd1, 1'b0}) begin
      bad++;
      $display("FAIL err_first: err=%b ea=%h ec=%0d v=%b, want 1/0800/1/0",
               addr_err, err_addr, err_count, bb_req_valid);
    end
    bus_req_addr = 16'h2000;
    step();
    bus_req_valid = 1'b0;
    total++;
    if ({addr_err, err_addr, err_count, bb_req_valid} !==
        {1'b1, 16'h2000, 8'd2, 1'b0}) begin
      bad++;
      $display("FAIL err_second: err=%b ea=%h ec=%0d v=%b, want 1/2000/2/0",
               addr_err, err_addr, err_count, bb_req_valid);
    end
    step();
    total++;
    if ({addr_err, err_addr} !== {1'b0, 16'h2000}) begin
      bad++;
      $display("FAIL err_pulse_end: err=%b ea=%h, want 0/2000",
               addr_err, err_addr);
    end
  endtask

  task automatic test_full();
    bb_req_ready = 1'b0;
    send(16'h0001, 1'b1, 8'h11);
    send(16'h0002, 1'b0, 8'h22);
    total++;
    if ({bus_req_ready, bb_req_valid} !== 2'b01) begin
      bad++;
      $display("FAIL full_ready: ready=%b v=%b, want 0/1",
               bus_req_ready, bb_req_valid);
    end
    fork
      send(16'h0003, 1'b1, 8'h33);
      begin
        step();
        step();
        total++;
        if ({bus_req_ready, bb_addr, bb_wdata} !== {1'b0, 12'h001, 8'h11}) begin
          bad++;
          $display("FAIL full_hold: ready=%b a=%h wd=%h, want 0/001/11",
                   bus_req_ready, bb_addr, bb_wdata);
        end
        bb_req_ready = 1'b1;
      end
    join
    drain();
  endtask

  task automatic test_push_pop();
    bb_req_ready = 1'b0;
    send(16'h0100, 1'b0, 8'hA1);
    bb_req_ready = 1'b1;
    send(16'h1234, 1'b1, 8'hB2);
    total++;
    if ({bb_req_valid, bus_req_ready, bb_addr, bb_wdata} !==
        {1'b1, 1'b1, 12'hA34, 8'hB2}) begin
      bad++;
      $display("FAIL push_pop: v=%b rdy=%b a=%h wd=%h, want 1/1/a34/b2",
               bb_req_valid, bus_req_ready, bb_addr, bb_wdata);
    end
    drain();
    step();
    total++;
    if (bb_req_valid !== 1'b0) begin
      bad++;
      $display("FAIL push_pop_empty: valid=%b, want 0", bb_req_valid);
    end
  endtask

  task automatic test_err_saturate();
    bus_req_valid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      bus_req_addr = 16'hE000 | 16'(i);
      step();
    end
    total++;
    if ({err_count, addr_err} !== {8'd255, 1'b1}) begin
      bad++;
      $display("FAIL err_saturate: ec=%0d err=%b, want 255/1",
               err_count, addr_err);
    end
    err_clr      = 1'b1;
    bus_req_addr = 16'h0800;
    step();
    err_clr       = 1'b0;
    bus_req_valid = 1'b0;
    total++;
    if (err_count !== 8'd1) begin
      bad++;
      $display("FAIL err_clr_inc: ec=%0d, want 1", err_count);
    end
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    total++;
    if (err_count !== 8'd0) begin
      bad++;
      $display("FAIL err_clr_only: ec=%0d, want 0", err_count);
    end
  endtask

  task automatic test_async_reset();
    bb_req_ready = 1'b0;
    send(16'h4000, 1'b0, 8'h00);
    send(16'h0010, 1'b1, 8'h01);
    send(16'h0020, 1'b1, 8'h02);
    total++;
    if ({bb_req_valid, bus_req_ready, err_count} !== {1'b1, 1'b0, 8'd1}) begin
      bad++;
      $display("FAIL pre_reset: v=%b rdy=%b ec=%0d, want 1/0/1",
               bb_req_valid, bus_req_ready, err_count);
    end
    #2;
    rstn = 1'b0;
    #1;
    total++;
    if ({bb_req_valid, bus_req_ready, err_count, bb_addr} !==
        {1'b0, 1'b1, 8'd0, 12'h0}) begin
      bad++;
      $display("FAIL async_reset: v=%b rdy=%b ec=%0d a=%h, want 0/1/0/000",
               bb_req_valid, bus_req_ready, err_count, bb_addr);
    end
    sbq.delete();
    step();
    rstn = 1'b1;
    bb_req_ready = 1'b1;
    send(16'h0FFF, 1'b0, 8'h77);
    drain();
  endtask

  initial begin
    rstn          = 1'b0;
    bus_req_valid = 1'b0;
    bus_req_addr  = '0;
    bus_req_we    = 1'b0;
    bus_req_wdata = '0;
    bb_req_ready  = 1'b0;
    err_clr       = 1'b0;
    repeat (3) step();
    test_reset();
    rstn = 1'b1;
    step();
    test_reset();
    test_single();
    test_window_err();
    test_full();
    test_push_pop();
    test_err_saturate();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
